// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and defaults for the AES core scheduler
package aes_pkg;
   localparam int LAT_DEF      = 10;
   localparam int KEY_WAIT_DEF = 2;
   localparam int TAGW_DEF     = 4;

   typedef enum logic [2:0] {
      S_NOKEY,
      S_KEY_PULSE,
      S_KEY_WAIT,
      S_RUN,
      S_DRAIN
   } state_t;

   // Tags travel through the latency line at the package width
   typedef struct packed {
      logic                valid;
      logic                is_dec;
      logic [TAGW_DEF-1:0] tag;
   } entry_t;
endpackage

// File: rtl/aes_ctrl_sched_if.sv
// rtl/aes_ctrl_sched_if.sv - request, core and result signals of the AES scheduler
interface aes_ctrl_sched_if #(
   parameter int TAGW = 4
);
   logic            key_valid;
   logic [127:0]    key_in;
   logic            key_ready;
   logic            enc_valid;
   logic [127:0]    enc_data;
   logic [TAGW-1:0] enc_tag;
   logic            enc_ready;
   logic            dec_valid;
   logic [127:0]    dec_data;
   logic [TAGW-1:0] dec_tag;
   logic            dec_ready;
   logic [127:0]    core_key;
   logic            fsm_en_enc;
   logic            fsm_en_dec;
   logic [127:0]    core_enc_in;
   logic [127:0]    core_dec_in;
   logic            core_enc_en;
   logic            core_dec_en;
   logic [127:0]    core_enc_out;
   logic [127:0]    core_dec_out;
   logic            res_valid;
   logic            res_is_dec;
   logic [TAGW-1:0] res_tag;
   logic [127:0]    res_data;
   logic            busy;

   modport slave (
      input  key_valid, key_in, enc_valid, enc_data, enc_tag,
             dec_valid, dec_data, dec_tag, core_enc_out, core_dec_out,
      output key_ready, enc_ready, dec_ready, core_key, fsm_en_enc, fsm_en_dec,
             core_enc_in, core_dec_in, core_enc_en, core_dec_en,
             res_valid, res_is_dec, res_tag, res_data, busy
   );

   modport master (
      output key_valid, key_in, enc_valid, enc_data, enc_tag,
             dec_valid, dec_data, dec_tag, core_enc_out, core_dec_out,
      input  key_ready, enc_ready, dec_ready, core_key, fsm_en_enc, fsm_en_dec,
             core_enc_in, core_dec_in, core_enc_en, core_dec_en,
             res_valid, res_is_dec, res_tag, res_data, busy
   );
endinterface

// File: rtl/aes_rr_arb2.sv
// rtl/aes_rr_arb2.sv - two-way round-robin arbiter, enc favoured out of reset
module aes_rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_req_enc,
   input  logic i_req_dec,
   output logic o_gnt_enc,
   output logic o_gnt_dec
);
   logic r_prio_dec;
   logic w_gnt_enc;
   logic w_gnt_dec;

   always_comb begin
      w_gnt_enc = i_en & i_req_enc & (~r_prio_dec | ~i_req_dec);
      w_gnt_dec = i_en & i_req_dec & (r_prio_dec | ~i_req_enc);
   end

   // Priority flips to the other channel after every grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_prio_dec <= 1'b0;
      end else if (w_gnt_enc) begin
         r_prio_dec <= 1'b1;
      end else if (w_gnt_dec) begin
         r_prio_dec <= 1'b0;
      end
   end

   assign o_gnt_enc = w_gnt_enc;
   assign o_gnt_dec = w_gnt_dec;
endmodule

// File: rtl/aes_ctrl_sched.sv
// rtl/aes_ctrl_sched.sv - key/data scheduler for one encrypt and one decrypt AES core
module aes_ctrl_sched
   import aes_pkg::*;
#(
   parameter int LAT      = LAT_DEF,
   parameter int KEY_WAIT = KEY_WAIT_DEF,
   parameter int TAGW     = TAGW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   aes_ctrl_sched_if.slave  bus
);
   localparam int CW = $clog2(LAT + 1);
   localparam int WW = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;

   state_t        r_state;
   state_t        w_next;
   logic [WW-1:0] r_wait_cnt;
   logic [127:0]  r_core_key;
   logic [127:0]  r_pend_key;
   entry_t        r_sr [LAT];
   logic [CW-1:0] r_inflight;

   logic   w_key_ready;
   logic   w_arb_en;
   logic   w_fsm_en;
   logic   w_ld_core;
   logic   w_core_from_in;
   logic   w_ld_pend;
   logic   w_gnt_enc;
   logic   w_gnt_dec;
   logic   w_issue;
   logic   w_res_valid;
   entry_t w_out;
   entry_t w_new;

   aes_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_arb_en),
      .i_req_enc (bus.enc_valid),
      .i_req_dec (bus.dec_valid),
      .o_gnt_enc (w_gnt_enc),
      .o_gnt_dec (w_gnt_dec)
   );

   assign w_issue = w_gnt_enc | w_gnt_dec;
   assign w_out   = r_sr[LAT-1];

   always_comb begin
      w_next         = r_state;
      w_key_ready    = 1'b0;
      w_arb_en       = 1'b0;
      w_fsm_en       = 1'b0;
      w_ld_core      = 1'b0;
      w_core_from_in = 1'b0;
      w_ld_pend      = 1'b0;
      case (r_state)
         S_NOKEY: begin
            w_key_ready = 1'b1;
            if (bus.key_valid) begin
               w_next         = S_KEY_PULSE;
               w_ld_core      = 1'b1;
               w_core_from_in = 1'b1;
            end
         end
         S_KEY_PULSE: begin
            w_fsm_en = 1'b1;
            w_next   = S_KEY_WAIT;
         end
         S_KEY_WAIT: begin
            if (r_wait_cnt == WW'(KEY_WAIT - 1)) begin
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            // A key request pre-empts any data issue in the same cycle
            if (bus.key_valid) begin
               w_key_ready = 1'b1;
               if (r_inflight == '0) begin
                  w_next         = S_KEY_PULSE;
                  w_ld_core      = 1'b1;
                  w_core_from_in = 1'b1;
               end else begin
                  w_next    = S_DRAIN;
                  w_ld_pend = 1'b1;
               end
            end else begin
               w_arb_en = 1'b1;
            end
         end
         S_DRAIN: begin
            if (r_inflight == '0) begin
               w_next    = S_KEY_PULSE;
               w_ld_core = 1'b1;
            end
         end
         default: w_next = S_NOKEY;
      endcase
      if (!rst) begin
         w_key_ready = (r_state == S_NOKEY);
         w_arb_en    = 1'b0;
         w_fsm_en    = 1'b0;
      end
   end

   always_comb begin
      w_new        = '0;
      w_new.valid  = w_issue;
      w_new.is_dec = w_gnt_dec;
      w_new.tag    = w_gnt_dec ? TAGW_DEF'(bus.dec_tag) : TAGW_DEF'(bus.enc_tag);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_NOKEY;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= (r_state == S_KEY_WAIT) ? r_wait_cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_core_key <= '0;
         r_pend_key <= '0;
         r_inflight <= '0;
         for (int i = 0; i < LAT; i++) begin
            r_sr[i] <= '0;
         end
      end else begin
         if (w_ld_core) begin
            r_core_key <= w_core_from_in ? bus.key_in : r_pend_key;
         end
         if (w_ld_pend) begin
            r_pend_key <= bus.key_in;
         end
         r_sr[0] <= w_new;
         for (int i = 1; i < LAT; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
         case ({w_issue, w_out.valid})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign w_res_valid = rst & w_out.valid;

   assign bus.key_ready   = w_key_ready;
   assign bus.enc_ready   = w_gnt_enc;
   assign bus.dec_ready   = w_gnt_dec;
   assign bus.core_key    = rst ? r_core_key : '0;
   assign bus.fsm_en_enc  = w_fsm_en;
   assign bus.fsm_en_dec  = w_fsm_en;
   assign bus.core_enc_in = w_gnt_enc ? bus.enc_data : '0;
   assign bus.core_dec_in = w_gnt_dec ? bus.dec_data : '0;
   assign bus.core_enc_en = w_gnt_enc;
   assign bus.core_dec_en = w_gnt_dec;
   assign bus.res_valid   = w_res_valid;
   assign bus.res_is_dec  = w_res_valid & w_out.is_dec;
   assign bus.res_tag     = w_res_valid ? TAGW'(w_out.tag) : '0;
   assign bus.res_data    = !w_res_valid ? '0 :
                            (w_out.is_dec ? bus.core_dec_out : bus.core_enc_out);
   assign bus.busy        = rst & ((r_inflight != '0) || (r_state == S_KEY_PULSE) ||
                                   (r_state == S_KEY_WAIT) || (r_state == S_DRAIN));
endmodule

// File: tb/tb_aes_ctrl_sched.sv
// tb/tb_aes_ctrl_sched.sv - scoreboard bench for aes_ctrl_sched with latency-line core models
module tb_aes_ctrl_sched;
   localparam int LAT  = 10;
   localparam int KW   = 2;
   localparam int TAGW = 4;
   localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] MIX = 128'h9e3779b97f4a7c15f39cc0605cedc834;

   typedef struct {
      logic            is_dec;
      logic [TAGW-1:0] tag;
      logic [127:0]    data;
      int              cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;
   int           n_res   = 0;
   logic [127:0] tb_key  = '0;
   exp_t         sb [$];
   logic [127:0] pe [LAT];
   logic [127:0] pd [LAT];

   always #5 clk = ~clk;

   aes_ctrl_sched_if #(.TAGW(TAGW)) bus ();

   aes_ctrl_sched #(.LAT(LAT), .KEY_WAIT(KW), .TAGW(TAGW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [127:0] mock_core(input logic dec, input logic [127:0] d,
                                               input logic [127:0] k);
      if (k == K0 && !dec && d == PT) return CT;
      if (k == K0 && dec && d == CT) return PT;
      return d ^ k ^ MIX;
   endfunction

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Core models: result appears LAT cycles after the enable is sampled
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
         pe[i] <= pe[i-1];
         pd[i] <= pd[i-1];
      end
      pe[0] <= bus.core_enc_en ? mock_core(1'b0, bus.core_enc_in, bus.core_key) : '0;
      pd[0] <= bus.core_dec_en ? mock_core(1'b1, bus.core_dec_in, bus.core_key) : '0;
   end
   assign bus.core_enc_out = pe[LAT-1];
   assign bus.core_dec_out = pd[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (bus.res_valid) begin
         n_res++;
         if (sb.size() == 0) begin
            check_val("res_unexpected", 1, 0);
         end else begin
            e = sb.pop_front();
            check_val("res_data", bus.res_data, e.data);
            check_val("res_tag", 128'(bus.res_tag), 128'(e.tag));
            check_val("res_is_dec", 128'(bus.res_is_dec), 128'(e.is_dec));
            check_val("res_lat", 128'(cyc - e.cyc), 128'(LAT));
         end
      end
      if (bus.enc_valid && bus.enc_ready)
         sb.push_back('{1'b0, bus.enc_tag, mock_core(1'b0, bus.enc_data, tb_key), cyc});
      if (bus.dec_valid && bus.dec_ready)
         sb.push_back('{1'b1, bus.dec_tag, mock_core(1'b1, bus.dec_data, tb_key), cyc});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic dec, input logic [127:0] d, input logic [TAGW-1:0] t);
      logic got;
      got = 1'b0;
      if (dec) begin
         bus.dec_valid = 1'b1; bus.dec_data = d; bus.dec_tag = t;
      end else begin
         bus.enc_valid = 1'b1; bus.enc_data = d; bus.enc_tag = t;
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if ((dec && bus.dec_ready) || (!dec && bus.enc_ready)) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) check_val("send_timeout", 0, 1);
      tick();
      bus.enc_valid = 1'b0;
      bus.dec_valid = 1'b0;
   endtask

   task automatic wait_empty(input int max);
      for (int i = 0; i < max; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check_val("sb_empty", 128'(sb.size()), 0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic got;
      int   res_before;
      bus.key_valid = 1'b0; bus.key_in = '0;
      bus.enc_valid = 1'b1; bus.enc_data = '0; bus.enc_tag = '0;
      bus.dec_valid = 1'b0; bus.dec_data = '0; bus.dec_tag = '0;

      tick();
      @(negedge clk);
      check_val("rst_key_ready", 128'(bus.key_ready), 1);
      check_val("rst_enc_ready", 128'(bus.enc_ready), 0);
      check_val("rst_busy", 128'(bus.busy), 0);
      check_val("rst_res_valid", 128'(bus.res_valid), 0);
      check_val("rst_core_key", bus.core_key, 0);
      check_val("rst_fsm_en", 128'(bus.fsm_en_enc), 0);
      tick();
      rst = 1'b1;
      bus.enc_valid = 1'b0;

      // Key load and the first encrypt vector
      bus.key_valid = 1'b1; bus.key_in = K0; tb_key = K0;
      @(negedge clk);
      check_val("key_accept", 128'(bus.key_ready), 1);
      tick();
      bus.key_valid = 1'b0;
      bus.enc_valid = 1'b1; bus.enc_data = PT; bus.enc_tag = 4'd3;
      @(negedge clk);
      check_val("pulse_enc", 128'(bus.fsm_en_enc), 1);
      check_val("pulse_dec", 128'(bus.fsm_en_dec), 1);
      check_val("pulse_key", bus.core_key, K0);
      check_val("pulse_ready", 128'(bus.enc_ready), 0);
      check_val("pulse_busy", 128'(bus.busy), 1);
      tick();
      bus.key_valid = 1'b1; bus.key_in = K1;
      @(negedge clk);
      check_val("wait_key_ign", 128'(bus.key_ready), 0);
      check_val("wait1_ready", 128'(bus.enc_ready), 0);
      check_val("wait1_fsm_en", 128'(bus.fsm_en_enc), 0);
      tick();
      bus.key_valid = 1'b0;
      @(negedge clk);
      check_val("wait2_ready", 128'(bus.enc_ready), 0);
      tick();
      @(negedge clk);
      check_val("run_ready", 128'(bus.enc_ready), 1);
      tick();
      bus.enc_valid = 1'b0;
      wait_empty(LAT + 5);

      // Decrypt of the known ciphertext
      send(1'b1, CT, 4'd5);
      wait_empty(LAT + 5);

      // Both channels requesting: grants alternate starting with enc
      bus.enc_valid = 1'b1; bus.dec_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.enc_data = rnd128(); bus.enc_tag = TAGW'(i);
         bus.dec_data = rnd128(); bus.dec_tag = TAGW'(i + 8);
         @(negedge clk);
         check_val("rr_enc", 128'(bus.enc_ready), 128'(i % 2 == 0));
         check_val("rr_dec", 128'(bus.dec_ready), 128'(i % 2 == 1));
         tick();
      end
      bus.enc_valid = 1'b0; bus.dec_valid = 1'b0;
      wait_empty(LAT + 5);

      // Key change with three operations in flight
      bus.enc_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.enc_data = rnd128(); bus.enc_tag = TAGW'(i + 1);
         @(negedge clk);
         tick();
      end
      bus.key_valid = 1'b1; bus.key_in = K1; bus.enc_data = rnd128();
      @(negedge clk);
      check_val("key_in_run", 128'(bus.key_ready), 1);
      check_val("key_wins", 128'(bus.enc_ready), 0);
      tick();
      bus.key_valid = 1'b0; tb_key = K1;
      @(negedge clk);
      check_val("drain_busy", 128'(bus.busy), 1);
      check_val("drain_ready", 128'(bus.enc_ready), 0);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.fsm_en_enc) begin
            got = 1'b1;
            break;
         end
      end
      check_val("drain_pulse", 128'(got), 1);
      check_val("drain_done_first", 128'(sb.size()), 0);
      check_val("new_core_key", bus.core_key, K1);
      tick();
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.enc_ready) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      check_val("new_key_issue", 128'(got), 1);
      tick();
      bus.enc_valid = 1'b0;
      wait_empty(LAT + 5);

      // Reset with five operations in flight
      bus.enc_valid = 1'b1; bus.dec_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.enc_data = rnd128(); bus.dec_data = rnd128();
         @(negedge clk);
         tick();
      end
      rst = 1'b0; bus.enc_valid = 1'b0; bus.dec_valid = 1'b0;
      @(negedge clk);
      check_val("mid_rst_busy", 128'(bus.busy), 0);
      check_val("mid_rst_key", bus.core_key, 0);
      tick();
      rst = 1'b1;
      sb.delete();
      res_before = n_res;
      bus.enc_valid = 1'b1;
      @(negedge clk);
      check_val("post_rst_nokey", 128'(bus.key_ready), 1);
      check_val("post_rst_ready", 128'(bus.enc_ready), 0);
      check_val("post_rst_busy", 128'(bus.busy), 0);
      tick();
      bus.enc_valid = 1'b0;
      repeat (LAT + 5) tick();
      check_val("post_rst_quiet", 128'(n_res - res_before), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end
endmodule
